// File: rtl/freq_meter_if.sv
// Measured-signal input and BCD result bundle for the frequency meter.
// The meter sits on the slave side; whoever supplies sigin is the master.
interface freq_meter_if;
    logic        sigin;
    logic [15:0] bcd;
    logic        ovf;
    logic        valid;

    modport master (
        output sigin,
        input  bcd,
        input  ovf,
        input  valid
    );

    modport slave (
        input  sigin,
        output bcd,
        output ovf,
        output valid
    );
endinterface

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sigin over a GATE_CYCLES-long window
// in saturating 4-digit BCD and latches the result with a valid strobe.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned N           = 32
) (
    input  logic         clkin,
    input  logic         rst,
    freq_meter_if.slave  io
);
    localparam logic [N-1:0] LAST = N'(GATE_CYCLES - 1);

    logic         s1;
    logic         s2;
    logic         sp;
    logic [N-1:0] g;
    logic [15:0]  w;
    logic         wo;
    logic [15:0]  bcd_q;
    logic         ovf_q;
    logic         valid_q;

    logic         hit;
    logic         sat;
    logic         close;
    logic [15:0]  inc;
    logic         c;
    logic [15:0]  w_nx;
    logic         wo_nx;

    assign hit   = s2 & ~sp;
    assign sat   = (w == 16'h9999);
    assign close = (g == LAST);

    // Single-cycle ripple of the BCD +1 through all four digits.
    always_comb begin
        inc = w;
        c   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (w[4*i +: 4] >= 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = w[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
    end

    assign w_nx  = (hit && !sat) ? inc : w;
    assign wo_nx = wo | (hit & sat);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            sp <= 1'b0;
        end else begin
            s1 <= io.sigin;
            s2 <= s1;
            sp <= s2;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            g       <= '0;
            w       <= '0;
            wo      <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= close;
            if (close) begin
                g     <= '0;
                bcd_q <= w_nx;
                ovf_q <= wo_nx;
                w     <= '0;
                wo    <= 1'b0;
            end else begin
                g  <= g + N'(1);
                w  <= w_nx;
                wo <= wo_nx;
            end
        end
    end

    assign io.bcd   = bcd_q;
    assign io.ovf   = ovf_q;
    assign io.valid = valid_q;
endmodule

// File: tb/tb_freq_meter.sv
// Three meters with different gate lengths driven by randomized square waves
// and checked against an edge-list window model.
module tb_freq_meter;
    localparam int G0 = 100;
    localparam int G1 = 10000;
    localparam int G2 = 40000;
    localparam int NW = 1024;

    int gs [3] = '{G0, G1, G2};

    logic       clkin = 1'b0;
    logic [2:0] rst;
    logic [2:0] sig;

    always #5 clkin = ~clkin;

    freq_meter_if i0 ();
    freq_meter_if i1 ();
    freq_meter_if i2 ();

    assign i0.sigin = sig[0];
    assign i1.sigin = sig[1];
    assign i2.sigin = sig[2];

    freq_meter #(.GATE_CYCLES(G0), .N(32)) u0 (
        .clkin(clkin), .rst(rst[0]), .io(i0)
    );
    freq_meter #(.GATE_CYCLES(G1), .N(32)) u1 (
        .clkin(clkin), .rst(rst[1]), .io(i1)
    );
    freq_meter #(.GATE_CYCLES(G2), .N(32)) u2 (
        .clkin(clkin), .rst(rst[2]), .io(i2)
    );

    logic [15:0] bcd [3];
    logic        ovf [3];
    logic        vld [3];

    assign bcd[0] = i0.bcd;
    assign bcd[1] = i1.bcd;
    assign bcd[2] = i2.bcd;
    assign ovf[0] = i0.ovf;
    assign ovf[1] = i1.ovf;
    assign ovf[2] = i2.ovf;
    assign vld[0] = i0.valid;
    assign vld[1] = i1.valid;
    assign vld[2] = i2.valid;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Model: e numbers clkin edges with the reset-release edge as 1.
    // A sampled 0->1 of sigin at edge k lands in window k / G.
    int          e   [3];
    bit          prv [3];
    int          cnt [3][NW];
    logic [15:0] xb  [3];
    bit          xo  [3];

    always @(posedge clkin) begin
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                e[d]   = 1;
                prv[d] = 1'b0;
                for (int j = 0; j < NW; j++) cnt[d][j] = 0;
            end else begin
                e[d]++;
                if (sig[d] && !prv[d] && (e[d] / gs[d]) < NW)
                    cnt[d][e[d] / gs[d]]++;
                prv[d] = sig[d];
            end
        end
    end

    always @(negedge clkin) begin
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                xb[d] = 16'h0000;
                xo[d] = 1'b0;
                chk($sformatf("rst_valid%0d", d), 32'(vld[d]), 32'd0);
                chk($sformatf("rst_bcd%0d", d), 32'(bcd[d]), 32'd0);
                chk($sformatf("rst_ovf%0d", d), 32'(ovf[d]), 32'd0);
            end else begin
                automatic int  g = gs[d];
                automatic bit  v = (e[d] > g) && (e[d] % g == 1);
                if (v) begin
                    automatic int c = cnt[d][e[d] / g - 1];
                    xb[d] = to_bcd(c > 9999 ? 9999 : c);
                    xo[d] = (c > 9999);
                end
                chk($sformatf("valid%0d", d), 32'(vld[d]), 32'(v));
                if (v || (e[d] % g == 0)) begin
                    chk($sformatf("bcd%0d", d), 32'(bcd[d]), 32'(xb[d]));
                    chk($sformatf("ovf%0d", d), 32'(ovf[d]), 32'(xo[d]));
                end
            end
        end
    end

    task automatic drive(input int d, input int hi, input int lo, input int n);
        automatic int per = (hi + lo > 0) ? hi + lo : 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clkin);
            sig[d] = ((i % per) < hi);
        end
    endtask

    task automatic wait_valid(input int d, input int lim);
        int i;
        for (i = 0; i < lim && !vld[d]; i++) @(negedge clkin);
        chk($sformatf("wait_valid%0d", d), 32'(vld[d]), 32'd1);
    endtask

    task automatic run0;
        int ph;
        drive(0, 0, 1, 300);
        chk("idle_bcd", 32'(bcd[0]), 32'h0000);
        chk("idle_ovf", 32'(ovf[0]), 32'd0);
        drive(0, 5, 5, 400);
        chk("basic_bcd", 32'(bcd[0]), 32'h0010);
        ph = 0;
        for (int i = 0; i < 200 && (e[0] % G0) != 57; i++) begin
            @(negedge clkin);
            sig[0] = ((ph % 10) < 5);
            ph++;
        end
        @(posedge clkin);
        #2 rst[0] = 1'b1;
        #1;
        chk("async_bcd", 32'(bcd[0]), 32'd0);
        chk("async_ovf", 32'(ovf[0]), 32'd0);
        chk("async_valid", 32'(vld[0]), 32'd0);
        repeat (3) @(negedge clkin);
        @(posedge clkin);
        rst[0] <= 1'b0;
        drive(0, 5, 5, 400);
        chk("post_rst_bcd", 32'(bcd[0]), 32'h0010);
        @(posedge clkin);
        #2 rst[0] = 1'b1;
        sig[0] = 1'b1;
        repeat (2) @(negedge clkin);
        @(posedge clkin);
        rst[0] <= 1'b0;
        drive(0, 1, 0, 99);
        wait_valid(0, 5);
        chk("rsthi_bcd", 32'(bcd[0]), 32'h0001);
        drive(0, 1, 0, 110);
        chk("rsthi_bcd2", 32'(bcd[0]), 32'h0000);
        for (int s = 0; s < 30; s++)
            drive(0, $urandom_range(1, 8), $urandom_range(1, 8),
                  $urandom_range(20, 300));
        drive(0, 0, 1, 10);
    endtask

    task automatic run1;
        drive(1, 5, 5, 9999);
        wait_valid(1, 5);
        chk("carry_bcd", 32'(bcd[1]), 32'h1000);
        chk("carry_ovf", 32'(ovf[1]), 32'd0);
        while (e[1] < 70000)
            drive(1, $urandom_range(2, 9), $urandom_range(2, 9),
                  $urandom_range(500, 3000));
    endtask

    task automatic run2;
        drive(2, 2, 2, G2 - 1);
        wait_valid(2, 5);
        chk("sat_bcd", 32'(bcd[2]), 32'h9999);
        chk("sat_ovf", 32'(ovf[2]), 32'd1);
        drive(2, 0, 1, G2 + 5);
        chk("clr_bcd", 32'(bcd[2]), 32'h0000);
        chk("clr_ovf", 32'(ovf[2]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 3'b111;
        sig = 3'b000;
        repeat (3) @(posedge clkin);
        #1;
        chk("reset_bcd", 32'(bcd[0]), 32'd0);
        chk("reset_valid", 32'(vld[1]), 32'd0);
        @(posedge clkin);
        rst <= 3'b000;
        fork
            run0();
            run1();
            run2();
        join
        repeat (5) @(negedge clkin);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of clkin cycles. The gate is 1 s at 50 MHz by default. The result is presented as four packed BCD digits for the seven-segment display path. The block is the measuring counterpart of the clock divider: the divider generates a known rate from clkin, and this block recovers an unknown rate against clkin. A new result and a one-cycle valid strobe are produced at the end of every window.

## Interface
- GATE_CYCLES, 50000000, gate window length in clkin cycles; must be ≥ 4.
- N, 32, width of the gate counter; must satisfy 2^N > GATE_CYCLES.
- clkin  input  1  sole clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- sigin  input  1  signal to measure; asynchronous to clkin.
- bcd  output  16  last latched edge count, packed BCD; bcd[15:12] is thousands, bcd[3:0] is units.
- ovf  output  1  last latched window had more than 9999 edges.
- valid  output  1  one-cycle strobe; high in the cycle after bcd/ovf update.

## Operation
- **Synchronizer:** sigin passes through a 2-flop synchronizer (s1, s2), then a previous-value flop sp. The edge condition is s2 & ~sp.
- **Reset:** s1, s2 and sp all reset to 0. A sigin that is high at reset release therefore counts as one edge.
- **Gate counter g (N bits):** counts 0 .. GATE_CYCLES-1 and wraps to 0. The close cycle is the cycle with g == GATE_CYCLES-1.
- **Working BCD count w (4 digits):** on an edge, w is incremented by one in BCD within a single cycle.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - Example: 0x0999 → 0x1000.
- **Saturation:** an edge while w == 0x9999 leaves w at 0x9999 and sets the sticky window flag wo.
- **Close cycle:**
  - bcd ← w, including an edge detected in that same cycle.
  - ovf ← wo, including saturation in that same cycle.
  - w ← 0 and wo ← 0.
  - The next window starts; an edge in the following cycle counts as 1 in the new window.
- **Valid:** asserted exactly in the cycle after each close cycle, otherwise 0.
- **Accuracy:** counting is exact when sigin is high ≥ 2 and low ≥ 2 clkin periods. Faster input gives an undefined count, but outputs remain well-formed BCD.
- **Reset (any time, including mid-window):**
  - Immediately forces g, w, wo, bcd, ovf and valid to 0.
  - The partial window is discarded.
- **Control structure:** there is no other state. Measurement runs continuously, with no start/stop control.

## Timing
- **Reset values:** bcd = 16'h0000, ovf = 0, valid = 0.
- **Edge latency:** a sigin rising edge sampled at clkin edge k increments w at edge k+2.
  - The edge is visible in s2 & ~sp during the cycle after edge k+1.
  - The counting window is delayed by the same 2–3 cycles. Windows are contiguous and non-overlapping, so no edge is lost or double-counted across windows.
- **First valid:** the first close cycle follows the GATE_CYCLES-th rising clkin edge after rst deasserts (g reaches GATE_CYCLES-1).
  - bcd/ovf update on the next edge, which is the (GATE_CYCLES+1)-th.
  - valid is high for the cycle after that edge.
- **Period:** subsequent valid pulses are exactly GATE_CYCLES cycles apart.
- **Stability:** bcd and ovf change only on the edge that raises valid, and hold for GATE_CYCLES cycles.
- **Simultaneous edge and close:** the edge belongs to the closing window.
- **Simultaneous edge at saturation and close:** ovf = 1 and bcd = 0x9999.

## Test plan
- **Idle input:** GATE_CYCLES = 100, sigin held 0 → valid pulses every 100 cycles, first after 101 clkin edges post-reset; bcd = 0x0000, ovf = 0.
- **Basic count:** GATE_CYCLES = 100, sigin period 10 (5 high, 5 low), any phase → every window after the first full one gives bcd = 0x0010, ovf = 0.
- **BCD carry chain:** GATE_CYCLES = 10000, sigin period 10 → bcd = 0x1000. GATE_CYCLES = 40000, period 8 → bcd = 0x5000, ovf = 0.
- **Saturation:** GATE_CYCLES = 40000, sigin period 4 (10000 edges) → bcd = 0x9999, ovf = 1. Next window with sigin held 0 → bcd = 0x0000, ovf = 0 (sticky flag cleared).
- **Reset mid-window:** GATE_CYCLES = 100, sigin period 10, assert rst at cycle 57 of a window asynchronously (between clock edges) → bcd, ovf and valid go to 0 immediately without a clock edge. After release, the first valid arrives 101 edges later with bcd = 0x0010 or 0x0011 depending on phase. Subsequent windows give 0x0010.
- **Reset-high sigin:** sigin held 1 through reset and after, GATE_CYCLES = 100 → first window bcd = 0x0001, then 0x0000.
